// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: raster pixel stream in, 3x3 window out; sof_i exists only with SOBEL_WIN_SOF_EN
interface sobel_window_gen_if;
    logic [7:0] pix_i;
    logic       valid_i;
`ifdef SOBEL_WIN_SOF_EN
    logic       sof_i;
`endif
    logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic       done_o;
    logic       frame_done_o;
`ifdef SOBEL_WIN_SOF_EN
    modport master (output pix_i, valid_i, sof_i,
                    input d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o);
    modport slave (input pix_i, valid_i, sof_i,
                   output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o);
`else
    modport master (output pix_i, valid_i,
                    input d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o);
    modport slave (input pix_i, valid_i,
                   output d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o, done_o, frame_done_o);
`endif
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: 3x3 sliding window over a raster stream using two line buffers; SOBEL_WIN_SOF_EN adds sof_i frame resync
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    typedef enum logic {FILL, RUN} state_t;
    state_t        state;
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row, next_row;
    logic [7:0]    lb0 [IMG_WIDTH];
    logic [7:0]    lb1 [IMG_WIDTH];
    logic [7:0]    win [9];
    logic [7:0]    top, mid;
    logic          sof, run, last_col, last;
    logic          done, frame_done;
`ifdef SOBEL_WIN_SOF_EN
    assign sof = bus.sof_i;
`else
    assign sof = 1'b0;
`endif
    // sof relocates the current pixel to (0,0) and masks windows, so every lookup uses the effective position
    always_comb begin
        cur_col  = sof ? '0 : col;
        cur_row  = sof ? '0 : row;
        run      = !sof && state == RUN;
        last_col = cur_col == CW'(IMG_WIDTH - 1);
        last     = last_col && cur_row == RW'(IMG_HEIGHT - 1);
        next_row = last ? '0 : last_col ? cur_row + 1'b1 : cur_row;
        top      = lb1[cur_col];
        mid      = lb0[cur_col];
    end
    // line buffers shift down one line per column; contents need no reset since FILL masks them
    always_ff @(posedge clk) begin
        if (bus.valid_i) begin
            lb1[cur_col] <= mid;
            lb0[cur_col] <= bus.pix_i;
        end
    end
    // raster position and phase; state goes RUN once the position reaches row 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
        end else if (bus.valid_i) begin
            col   <= last_col ? '0 : cur_col + 1'b1;
            row   <= next_row;
            state <= next_row >= RW'(2) ? RUN : FILL;
        end
    end
    // window shifts left on each accepted pixel; qualifiers pulse for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win        <= '{default: '0};
            done       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            done       <= 1'b0;
            frame_done <= 1'b0;
            if (bus.valid_i) begin
                win[0]     <= win[1];
                win[1]     <= win[2];
                win[2]     <= top;
                win[3]     <= win[4];
                win[4]     <= win[5];
                win[5]     <= mid;
                win[6]     <= win[7];
                win[7]     <= win[8];
                win[8]     <= bus.pix_i;
                done       <= run && cur_col >= CW'(2);
                frame_done <= run && last;
            end
        end
    end
    assign bus.d0_o         = win[0];
    assign bus.d1_o         = win[1];
    assign bus.d2_o         = win[2];
    assign bus.d3_o         = win[3];
    assign bus.d4_o         = win[4];
    assign bus.d5_o         = win[5];
    assign bus.d6_o         = win[6];
    assign bus.d7_o         = win[7];
    assign bus.d8_o         = win[8];
    assign bus.done_o       = done;
    assign bus.frame_done_o = frame_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed and randomized streams checked against an image-array reference model
module tb_sobel_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam logic [71:0] FIRST_WIN = 72'h000102_101112_202122;
    localparam logic [71:0] LAST_WIN  = 72'h111213_212223_313233;

    logic clk = 1'b0;
    logic rst = 1'b0;
    sobel_window_gen_if bus ();
    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int mr = 0;
    int mc = 0;
    int dc = 0;
    int fdc = 0;
    logic [7:0]  img [H][W];
    logic [71:0] exp_win;
    logic [71:0] first_win;
    logic        last_done;

    function automatic logic [71:0] obs_win();
        return {bus.d0_o, bus.d1_o, bus.d2_o, bus.d3_o, bus.d4_o, bus.d5_o, bus.d6_o, bus.d7_o, bus.d8_o};
    endfunction

    task automatic check(input logic ed, input logic ef, input bit chk_win, input string tag);
        logic [71:0] obs;
        obs = obs_win();
        vecs++;
        assert (bus.done_o === ed) else begin
            errs++;
            $error("FAIL %s done observed=%0b expected=%0b", tag, bus.done_o, ed);
        end
        vecs++;
        assert (bus.frame_done_o === ef) else begin
            errs++;
            $error("FAIL %s frame_done observed=%0b expected=%0b", tag, bus.frame_done_o, ef);
        end
        if (chk_win) begin
            vecs++;
            assert (obs === exp_win) else begin
                errs++;
                $error("FAIL %s window observed=%h expected=%h", tag, obs, exp_win);
            end
        end
        if (bus.done_o === 1'b1) begin
            if (dc == 0) first_win = obs;
            dc++;
        end
        if (bus.frame_done_o === 1'b1) fdc++;
    endtask

    task automatic push(input logic [7:0] p, input bit s, input int gap);
        logic ed, ef;
        bus.pix_i   = p;
        bus.valid_i = 1'b1;
`ifdef SOBEL_WIN_SOF_EN
        bus.sof_i = s;
        if (s) begin
            mr = 0;
            mc = 0;
        end
`endif
        img[mr][mc] = p;
        ed = mr >= 2 && mc >= 2;
        ef = mr == H - 1 && mc == W - 1;
        if (ed) exp_win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                           img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                           img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        if (mc == W - 1) begin
            mc = 0;
            mr = mr == H - 1 ? 0 : mr + 1;
        end else mc++;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.pix_i   = 8'($urandom);
`ifdef SOBEL_WIN_SOF_EN
        bus.sof_i = 1'b0;
`endif
        last_done = ed;
        check(ed, ef, ed, "accept");
        repeat (gap) begin
            @(negedge clk);
            check(1'b0, 1'b0, last_done, "gap");
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        vecs++;
        assert ({bus.done_o, bus.frame_done_o, obs_win()} === 74'd0) else begin
            errs++;
            $error("FAIL reset outputs observed=%h expected=0", {bus.done_o, bus.frame_done_o, obs_win()});
        end
        @(negedge clk);
        rst = 1'b0;
        mr = 0;
        mc = 0;
        last_done = 1'b0;
    endtask

    task automatic frame(input int gap, input bit rnd_pix, input bit first_sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                push(rnd_pix ? 8'($urandom) : 8'(r * 16 + c), first_sof && r == 0 && c == 0,
                     gap < 0 ? int'($urandom_range(0, 3)) : gap);
    endtask

    task automatic expect_count(input int got, input int want, input string tag);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.pix_i   = 8'h00;
`ifdef SOBEL_WIN_SOF_EN
        bus.sof_i = 1'b0;
`endif
        exp_win   = '0;
        first_win = '0;
        last_done = 1'b0;
        do_reset();
        // partial frame up to the first window, then asynchronous reset mid-cycle
        for (int i = 0; i < 11; i++) push(8'((i / W) * 16 + i % W), 1'b0, 0);
        vecs++;
        assert (obs_win() === FIRST_WIN) else begin
            errs++;
            $error("FAIL first_window observed=%h expected=%h", obs_win(), FIRST_WIN);
        end
        do_reset();
        dc = 0;
        for (int i = 0; i < 9; i++) push(8'((i / W) * 16 + i % W), 1'b0, 0);
        expect_count(dc, 0, "post_reset_nine");
        do_reset();
        // contiguous frame
        dc = 0;
        fdc = 0;
        frame(0, 1'b0, 1'b0);
        vecs++;
        assert (obs_win() === LAST_WIN) else begin
            errs++;
            $error("FAIL last_window observed=%h expected=%h", obs_win(), LAST_WIN);
        end
        expect_count(dc, 4, "contig_done");
        expect_count(fdc, 1, "contig_frame_done");
        // one valid cycle in three
        dc = 0;
        fdc = 0;
        frame(2, 1'b0, 1'b0);
        expect_count(dc, 4, "gapped_done");
        vecs++;
        assert (first_win === FIRST_WIN) else begin
            errs++;
            $error("FAIL gapped_first observed=%h expected=%h", first_win, FIRST_WIN);
        end
        // two back-to-back frames
        dc = 0;
        fdc = 0;
        frame(0, 1'b0, 1'b0);
        dc = 0;
        frame(0, 1'b0, 1'b0);
        vecs++;
        assert (first_win === FIRST_WIN) else begin
            errs++;
            $error("FAIL frame2_first observed=%h expected=%h", first_win, FIRST_WIN);
        end
        expect_count(dc, 4, "frame2_done");
        expect_count(fdc, 2, "b2b_frame_done");
        // reset after 7 pixels, then a full frame
        for (int i = 0; i < 7; i++) push(8'((i / W) * 16 + i % W), 1'b0, 0);
        do_reset();
        dc = 0;
        frame(0, 1'b0, 1'b0);
        expect_count(dc, 4, "reset7_done");
        vecs++;
        assert (first_win === FIRST_WIN) else begin
            errs++;
            $error("FAIL reset7_first observed=%h expected=%h", first_win, FIRST_WIN);
        end
        // randomized pixels and gaps
        for (int k = 0; k < 3; k++) begin
            dc = 0;
            fdc = 0;
            frame(-1, 1'b1, 1'b0);
            expect_count(dc, 4, "random_done");
            expect_count(fdc, 1, "random_frame_done");
        end
        // 5 stray pixels, then a frame that starts with sof when available
        do_reset();
        for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0, 0);
        dc = 0;
        frame(0, 1'b0, 1'b1);
`ifdef SOBEL_WIN_SOF_EN
        expect_count(dc, 4, "sof_done");
        vecs++;
        assert (first_win === FIRST_WIN) else begin
            errs++;
            $error("FAIL sof_first observed=%h expected=%h", first_win, FIRST_WIN);
        end
`else
        vecs++;
        assert (first_win !== FIRST_WIN) else begin
            errs++;
            $error("FAIL misaligned_first observed=%h expected=not %h", first_win, FIRST_WIN);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the Sobel calculation stage. It accepts one 8-bit grayscale pixel per valid cycle in raster order and stores the two previous image lines in line buffers. For every pixel position where a full 3x3 neighbourhood exists, it presents that neighbourhood as nine parallel pixels (`d0_o`..`d8_o`) with a one-cycle `done_o` qualifier, which maps directly onto the calculation stage's `d*_i`/`done_i` inputs.

## Interface
- `IMG_WIDTH`, 640, pixels per line (>= 3)
- `IMG_HEIGHT`, 480, lines per frame (>= 3)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pix_i`  in  8  input pixel, raster order
- `valid_i`  in  1  `pix_i` accepted on rising edge when high; no backpressure
- `sof_i`  in  1  start of frame, sampled with `valid_i` (present only with `SOBEL_WIN_SOF_EN`)
- `d0_o`..`d8_o`  out  8 each  window: `d0..d2` top row (line r-2), `d3..d5` middle (r-1), `d6..d8` bottom (r); left to right = columns c-2, c-1, c
- `done_o`  out  1  window valid, one pulse per qualifying accepted pixel
- `frame_done_o`  out  1  pulses with the window of the last pixel (H-1, W-1)

## Operation
- Counters: `col` in 0..IMG_WIDTH-1, `row` in 0..IMG_HEIGHT-1. Both advance only on accepted pixels. `col` wraps to 0 and increments `row`. At (H-1, W-1), both wrap to (0,0).
- Line buffers: `lb0` holds line r-1 and `lb1` holds line r-2, each IMG_WIDTH x 8 and addressed by `col`. On acceptance at column c:
  - read `lb1[c]` and `lb0[c]`;
  - write `lb1[c] <= lb0[c]` and `lb0[c] <= pix_i`.
- Window shift on acceptance:
  - the left column takes the old middle column, and the middle column takes the old right column;
  - the new right column is {`lb1[c]`, `lb0[c]`, `pix_i`} (top, middle, bottom), i.e. `d2_o`, `d5_o`, `d8_o`.
- Phase state machine, derived from `row`:
  - FILL while row < 2: no windows are emitted.
  - RUN while row >= 2.
  - FILL -> RUN on the first acceptance at row 2. RUN -> FILL on the wrap from (H-1, W-1).
- `done_o` is asserted in the cycle after acceptance when state = RUN and c >= 2. Columns 0..1 hold stale data from the previous line and are suppressed.
- `frame_done_o` is asserted in the same cycle as `done_o` for position (H-1, W-1).
- `d*_o` change only on acceptance. They hold their values between accepted pixels.
- Window registers, counters and state are reset. Line buffer contents are not reset; this is safe because FILL masks them.
- Reset mid-frame: all counters, state and outputs clear immediately. The next accepted pixel is (0,0).

## Timing
- Latency: pixel accepted at edge N produces its window on `d*_o`, plus `done_o`, after edge N, visible for cycle N+1.
- `done_o` and `frame_done_o` are single-cycle pulses. With continuous `valid_i` and c >= 2 in RUN, `done_o` stays high continuously.
- Gapped `valid_i` is allowed at any ratio. Output sequence is identical to the gapless case, only spread in time.
- Reset values: `d0_o`..`d8_o` = 0, `done_o` = 0, `frame_done_o` = 0, `row` = `col` = 0, state = FILL.
- Throughput: one pixel per clock. No stall path; the downstream stage must accept every `done_o`.

## Configuration
- `SOBEL_WIN_SOF_EN` defined:
  - `sof_i` port exists.
  - `valid_i && sof_i` forces the current pixel to position (0,0) and state to FILL, discarding any partial frame. The counters then continue from (0,1).
  - `sof_i` without `valid_i` is ignored.
- `SOBEL_WIN_SOF_EN` not defined: no `sof_i` port, and framing is purely by pixel count from reset.

## Test plan
All scenarios use IMG_WIDTH = 4, IMG_HEIGHT = 4, and pixel value = row*16 + col.
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately. No `done_o` for the next 9 accepted pixels.
- Contiguous frame 0x00..0x33 -> exactly 4 `done_o` pulses.
  - The first follows pixel 0x22 with d0..d8 = 00,01,02,10,11,12,20,21,22.
  - The last follows 0x33 with d0..d8 = 11,12,13,21,22,23,31,32,33, and `frame_done_o` = 1 in that cycle only.
- Same frame with `valid_i` high one cycle in three -> identical 4 windows, each `done_o` exactly one cycle after its accepting edge, and outputs held during gaps.
- Two back-to-back frames -> 8 `done_o` pulses. The first window of frame 2 equals the first window of frame 1, and `frame_done_o` pulses twice.
- Reset after 7 pixels, then a full frame -> exactly 4 windows, matching the contiguous-frame values.
- (`SOBEL_WIN_SOF_EN`) 5 pixels, then a full frame whose first pixel has `sof_i` = 1 -> exactly 4 windows with the contiguous-frame values. Without the macro, the same stimulus produces misaligned windows; the bench checks that only with the macro off.
